// File: rtl/interact_pkg.sv
// Shared types and constants for the interact register bank: sequencer
// states, control-slot offsets, control/status bit positions and a helper
// that packs the status word.
package interact_pkg;

   // Core-reset sequencer states
   typedef enum logic [0:0] {
      ST_HOLD = 1'b0,
      ST_RUN  = 1'b1
   } seq_state_e;

   // Byte offsets inside slot 0
   localparam logic [31:0] OFF_CTRL  = 32'h0000_0000;
   localparam logic [31:0] OFF_DIRTY = 32'h0000_0004;

   // Control write: bit that requests a core reset
   localparam int unsigned CTRL_RESET_BIT = 0;

   // Status read: bit positions
   localparam int unsigned STAT_BOOT_DONE_BIT = 0;
   localparam int unsigned STAT_RESET_SW_BIT  = 1;

   // Pack the slot-0 status word from the sequencer outputs
   function automatic logic [31:0] ctrl_status(input logic rst_held, input logic booted);
      logic [31:0] word;
      word                     = 32'h0000_0000;
      word[STAT_BOOT_DONE_BIT] = booted;
      word[STAT_RESET_SW_BIT]  = rst_held;
      return word;
   endfunction

endpackage

// File: rtl/interact_reset_seq.sv
// Retriggerable core-reset sequencer. Holds reset_sw high for exactly
// RESET_CYCLES cycles after the most recent trigger (or after bridge reset),
// then releases it and latches the sticky boot_done flag.
module interact_reset_seq
   import interact_pkg::*;
#(
   parameter int unsigned RESET_CYCLES = 8000
) (
   input  logic clk_74a,
   input  logic reset,
   input  logic trigger,
   output logic reset_sw,
   output logic boot_done
);

   localparam int unsigned     CNT_W    = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RESET_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

   seq_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             reset_sw_q, reset_sw_d;
   logic             boot_done_q, boot_done_d;

   // Next-state logic: a trigger always (re)starts a full hold, even on the expiry cycle
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      reset_sw_d  = reset_sw_q;
      boot_done_d = boot_done_q;
      if (trigger) begin
         state_d    = ST_HOLD;
         cnt_d      = CNT_LOAD;
         reset_sw_d = 1'b1;
      end else begin
         case (state_q)
            ST_HOLD: begin
               if (cnt_q == CNT_ZERO) begin
                  state_d     = ST_RUN;
                  reset_sw_d  = 1'b0;
                  boot_done_d = 1'b1;
               end else begin
                  cnt_d      = cnt_q - CNT_ONE;
                  reset_sw_d = 1'b1;
               end
            end
            ST_RUN: begin
               reset_sw_d = 1'b0;
            end
            default: begin
               state_d    = ST_HOLD;
               cnt_d      = CNT_LOAD;
               reset_sw_d = 1'b1;
            end
         endcase
      end
   end

   // Sequencer registers; bridge reset starts the power-on hold
   always_ff @(posedge clk_74a or posedge reset) begin
      if (reset) begin
         state_q     <= ST_HOLD;
         cnt_q       <= CNT_LOAD;
         reset_sw_q  <= 1'b1;
         boot_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         reset_sw_q  <= reset_sw_d;
         boot_done_q <= boot_done_d;
      end
   end

   assign reset_sw  = reset_sw_q;
   assign boot_done = boot_done_q;

endmodule

// File: rtl/interact_regbank.sv
// APF bridge register bank: NUM_REGS-1 generic 32-bit slots plus a
// control/status slot 0 with a clear-on-read DIRTY word, per-slot write
// strobes and a retriggerable core-reset sequencer. Single clock domain.
module interact_regbank
   import interact_pkg::*;
#(
   parameter int unsigned            NUM_REGS     = 12,
   parameter logic [31:0]            BASE_ADDR    = 32'hF000_0000,
   parameter int unsigned            SLOT_SHIFT   = 24,
   parameter logic [31:0]            RESET_MASK   = 32'h0000_0012,
   parameter int unsigned            RESET_CYCLES = 8000,
   parameter logic [NUM_REGS*32-1:0] INIT_VALUES  = '0
) (
   input  logic                     clk_74a,
   input  logic                     reset,
   input  logic [31:0]              bridge_addr,
   input  logic                     bridge_wr,
   input  logic [31:0]              bridge_wr_data,
   input  logic                     bridge_rd,
   output logic [31:0]              bridge_rd_data,
   output logic [NUM_REGS*32-1:0]   regs_out,
   output logic [NUM_REGS-1:0]      reg_wr_stb,
   output logic                     reset_sw,
   output logic                     boot_done
);

   localparam int unsigned IDX_W  = $clog2(NUM_REGS);
   localparam int unsigned HI_LSB = SLOT_SHIFT + IDX_W;

   // Address decode
   logic [IDX_W-1:0]      addr_idx_s;
   logic [SLOT_SHIFT-1:0] addr_off_s;
   logic                  base_ok_s;
   logic                  idx_ok_s;
   logic                  slot_hit_s;
   logic                  dirty_hit_s;
   logic [NUM_REGS-1:0]   sel_s;

   // Storage (slot 0 has no data register)
   logic [31:0]           regs_q [1:NUM_REGS-1];
   logic [31:0]           regs_d [1:NUM_REGS-1];
   logic [NUM_REGS-1:1]   dirty_q, dirty_d;
   logic [NUM_REGS-1:1]   dirty_clr_s;
   logic [NUM_REGS-1:0]   wr_stb_q, wr_stb_d;
   logic [31:0]           rd_data_q, rd_data_d;

   // Read helpers and sequencer interface
   logic [31:0]           rd_slot_val_s;
   logic [31:0]           dirty_word_s;
   logic                  trigger_s;
   logic                  seq_reset_sw_s;
   logic                  seq_boot_done_s;

   assign addr_idx_s  = bridge_addr[HI_LSB-1:SLOT_SHIFT];
   assign addr_off_s  = bridge_addr[SLOT_SHIFT-1:0];
   assign base_ok_s   = (bridge_addr[31:HI_LSB] == BASE_ADDR[31:HI_LSB]);
   assign idx_ok_s    = (32'(addr_idx_s) < NUM_REGS);
   assign slot_hit_s  = base_ok_s && idx_ok_s && (32'(addr_off_s) == OFF_CTRL);
   assign dirty_hit_s = base_ok_s && (addr_idx_s == '0) && (32'(addr_off_s) == OFF_DIRTY);

   // One-hot slot select for offset-0 hits
   always_comb begin
      sel_s = '0;
      for (int unsigned k = 0; k < NUM_REGS; k++) begin
         sel_s[k] = slot_hit_s && (32'(addr_idx_s) == k);
      end
   end

   // Core reset is requested by a CTRL write with the reset bit, or a write to a masked slot
   assign trigger_s = bridge_wr &&
                      ((sel_s[0] && bridge_wr_data[CTRL_RESET_BIT]) ||
                       (|(sel_s[NUM_REGS-1:1] & RESET_MASK[NUM_REGS-1:1])));

   // Read mux over the generic slots
   always_comb begin
      rd_slot_val_s = 32'h0000_0000;
      for (int unsigned k = 1; k < NUM_REGS; k++) begin
         rd_slot_val_s = rd_slot_val_s | (sel_s[k] ? regs_q[k] : 32'h0000_0000);
      end
   end

   // DIRTY word: flag k at bit k, bit 0 always zero
   always_comb begin
      dirty_word_s = 32'h0000_0000;
      for (int unsigned k = 1; k < NUM_REGS; k++) begin
         dirty_word_s[k] = dirty_q[k];
      end
   end

   // Read response; a DIRTY read clears exactly the flags it returns
   always_comb begin
      rd_data_d   = rd_data_q;
      dirty_clr_s = '0;
      if (bridge_rd && slot_hit_s) begin
         if (sel_s[0]) begin
            rd_data_d = ctrl_status(seq_reset_sw_s, seq_boot_done_s);
         end else begin
            rd_data_d = rd_slot_val_s;
         end
      end else if (bridge_rd && dirty_hit_s) begin
         rd_data_d   = dirty_word_s;
         dirty_clr_s = dirty_q;
      end else begin
         rd_data_d   = rd_data_q;
         dirty_clr_s = '0;
      end
   end

   // Slot writes, strobes and dirty flags; a new write outranks a same-cycle clear
   always_comb begin
      wr_stb_d = {NUM_REGS{bridge_wr}} & sel_s;
      dirty_d  = '0;
      for (int unsigned k = 1; k < NUM_REGS; k++) begin
         regs_d[k]  = (bridge_wr && sel_s[k]) ? bridge_wr_data : regs_q[k];
         dirty_d[k] = (dirty_q[k] && !dirty_clr_s[k]) || (bridge_wr && sel_s[k]);
      end
   end

   // Bank registers with asynchronous reset to the configured initial values
   always_ff @(posedge clk_74a or posedge reset) begin
      if (reset) begin
         for (int unsigned k = 1; k < NUM_REGS; k++) begin
            regs_q[k] <= INIT_VALUES[k*32 +: 32];
         end
         dirty_q   <= '0;
         wr_stb_q  <= '0;
         rd_data_q <= 32'h0000_0000;
      end else begin
         regs_q    <= regs_d;
         dirty_q   <= dirty_d;
         wr_stb_q  <= wr_stb_d;
         rd_data_q <= rd_data_d;
      end
   end

   interact_reset_seq #(
      .RESET_CYCLES (RESET_CYCLES)
   ) u_reset_seq (
      .clk_74a   (clk_74a),
      .reset     (reset),
      .trigger   (trigger_s),
      .reset_sw  (seq_reset_sw_s),
      .boot_done (seq_boot_done_s)
   );

   assign regs_out[31:0] = 32'h0000_0000;
   for (genvar g = 1; g < NUM_REGS; g++) begin : g_regs_out
      assign regs_out[g*32 +: 32] = regs_q[g];
   end

   assign bridge_rd_data = rd_data_q;
   assign reg_wr_stb     = wr_stb_q;
   assign reset_sw       = seq_reset_sw_s;
   assign boot_done      = seq_boot_done_s;

endmodule

// File: tb/tb_interact_regbank.sv
// Self-checking bench for interact_regbank with default parameters.
// A behavioural model (slot array, dirty set, "cycles of hold remaining")
// is compared against every DUT output on every falling edge.
module tb_interact_regbank;

   localparam int NR = 12;
   localparam int RC = 8000;
   localparam int VW = NR * 32;

   logic              clk_74a        = 1'b0;
   logic              reset          = 1'b1;
   logic [31:0]       bridge_addr    = 32'h0;
   logic              bridge_wr      = 1'b0;
   logic [31:0]       bridge_wr_data = 32'h0;
   logic              bridge_rd      = 1'b0;
   logic [31:0]       bridge_rd_data;
   logic [VW-1:0]     regs_out;
   logic [NR-1:0]     reg_wr_stb;
   logic              reset_sw;
   logic              boot_done;

   interact_regbank dut (
      .clk_74a        (clk_74a),
      .reset          (reset),
      .bridge_addr    (bridge_addr),
      .bridge_wr      (bridge_wr),
      .bridge_wr_data (bridge_wr_data),
      .bridge_rd      (bridge_rd),
      .bridge_rd_data (bridge_rd_data),
      .regs_out       (regs_out),
      .reg_wr_stb     (reg_wr_stb),
      .reset_sw       (reset_sw),
      .boot_done      (boot_done)
   );

   always #5 clk_74a = ~clk_74a;

   // Reference model state
   logic [31:0]   m_slot [NR];
   logic [31:0]   m_dirty;
   logic [NR-1:0] m_stb;
   logic [31:0]   m_rd;
   int            m_hold;
   bit            m_boot;
   logic [31:0]   trig_mask = 32'h0000_0012;
   int            safe_slots [10] = '{0, 2, 3, 5, 6, 7, 8, 9, 10, 11};

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check_eq(input string tag, input logic [VW-1:0] act, input logic [VW-1:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
   endtask

   task automatic model_reset();
      for (int k = 0; k < NR; k++) m_slot[k] = 32'h0;
      m_dirty = 32'h0;
      m_stb   = '0;
      m_rd    = 32'h0;
      m_hold  = RC;
      m_boot  = 1'b0;
   endtask

   task automatic check_all();
      logic [VW-1:0] exp_regs;
      for (int k = 0; k < NR; k++) exp_regs[k*32 +: 32] = m_slot[k];
      check_eq("regs_out", regs_out, exp_regs);
      check_eq("reg_wr_stb", reg_wr_stb, m_stb);
      check_eq("rd_data", bridge_rd_data, m_rd);
      check_eq("reset_sw", reset_sw, (m_hold > 0));
      check_eq("boot_done", boot_done, m_boot);
   endtask

   // One bus cycle: drive at the falling edge, model the rising edge, check at the next falling edge
   task automatic tick(input bit wr, input bit rd, input logic [31:0] addr, input logic [31:0] data);
      bit          base_ok, slot_hit, dirty_hit, trig;
      int          k, n_hold;
      logic [23:0] off;
      logic [31:0] n_rd, n_dirty;
      logic [NR-1:0] n_stb;
      bit          n_boot;
      bridge_wr      = wr;
      bridge_rd      = rd;
      bridge_addr    = addr;
      bridge_wr_data = data;
      base_ok   = (addr[31:28] == 4'hF);
      k         = int'(addr[27:24]);
      off       = addr[23:0];
      slot_hit  = base_ok && (k < NR) && (off == 24'h0);
      dirty_hit = base_ok && (k == 0) && (off == 24'h4);
      n_rd = m_rd; n_dirty = m_dirty; n_stb = '0; trig = 1'b0;
      n_hold = m_hold; n_boot = m_boot;
      if (rd && slot_hit) n_rd = (k == 0) ? {30'd0, (m_hold > 0), m_boot} : m_slot[k];
      if (rd && dirty_hit) begin
         n_rd    = m_dirty;
         n_dirty = 32'h0;
      end
      if (wr && slot_hit) begin
         n_stb[k] = 1'b1;
         if (k == 0) trig = data[0];
         else begin
            n_dirty[k] = 1'b1;
            trig       = trig_mask[k];
         end
      end
      if (trig) n_hold = RC;
      else if (m_hold > 0) begin
         n_hold = m_hold - 1;
         if (n_hold == 0) n_boot = 1'b1;
      end
      @(posedge clk_74a);
      if (wr && slot_hit && k != 0) m_slot[k] = data;
      m_rd = n_rd; m_dirty = n_dirty; m_stb = n_stb; m_hold = n_hold; m_boot = n_boot;
      @(negedge clk_74a);
      bridge_wr = 1'b0;
      bridge_rd = 1'b0;
      check_all();
   endtask

   task automatic tick_idle();
      tick(1'b0, 1'b0, $urandom, $urandom);
   endtask

   // Count idle cycles while reset_sw stays high (bounded)
   task automatic count_hold(output int n);
      n = 0;
      while (reset_sw === 1'b1 && n < 3 * RC) begin
         tick_idle();
         n++;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #1;
      model_reset();
      check_all();
      @(posedge clk_74a);
      @(negedge clk_74a);
      reset = 1'b0;
      check_all();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          n;
      logic [31:0] d2, d;
      logic [31:0] addr;
      bit          wr, rd;

      // Power-on reset and hold
      model_reset();
      repeat (2) @(posedge clk_74a);
      @(negedge clk_74a);
      check_all();
      reset = 1'b0;
      check_all();
      count_hold(n);
      check_eq("por_hold_len", n, RC);
      check_eq("por_boot_done", boot_done, 1'b1);
      tick(1'b0, 1'b1, 32'hF000_0000, 32'h0);
      check_eq("status_after_boot", bridge_rd_data, 32'h1);

      // Plain slot write
      tick(1'b1, 1'b0, 32'hF200_0000, 32'hA5A5_0001);
      check_eq("slot2_value", regs_out[2*32 +: 32], 32'hA5A5_0001);
      check_eq("slot2_stb", reg_wr_stb, 12'h004);
      check_eq("slot2_no_reset", reset_sw, 1'b0);
      tick_idle();
      check_eq("stb_one_cycle", reg_wr_stb, 12'h000);

      // Retriggered hold through slot 4
      tick(1'b1, 1'b0, 32'hF400_0000, $urandom);
      for (int i = 1; i < 5000; i++) begin
         if (i == 2500) begin
            tick(1'b0, 1'b1, 32'hF000_0000, 32'h0);
            check_eq("status_mid_hold", bridge_rd_data, 32'h3);
         end else tick_idle();
      end
      tick(1'b1, 1'b0, 32'hF400_0000, $urandom);
      count_hold(n);
      check_eq("retrigger_end", 5000 + n, 13000);

      // Dirty flags
      tick(1'b0, 1'b1, 32'hF000_0004, 32'h0);
      check_eq("dirty_initial", bridge_rd_data, 32'h14);
      d2 = $urandom;
      tick(1'b1, 1'b0, 32'hF200_0000, d2);
      tick(1'b1, 1'b0, 32'hF700_0000, $urandom);
      tick(1'b0, 1'b1, 32'hF000_0004, 32'h0);
      check_eq("dirty_2_7", bridge_rd_data, 32'h84);
      tick(1'b0, 1'b1, 32'hF000_0004, 32'h0);
      check_eq("dirty_cleared", bridge_rd_data, 32'h0);
      tick(1'b1, 1'b0, 32'hF300_0000, $urandom);
      tick(1'b0, 1'b1, 32'hF000_0004, 32'h0);
      check_eq("dirty_3", bridge_rd_data, 32'h8);

      // Misses
      tick(1'b1, 1'b0, 32'hF200_0010, 32'hDEAD_BEEF);
      check_eq("miss_off_stb", reg_wr_stb, 12'h000);
      tick(1'b1, 1'b0, 32'hFC00_0000, 32'hDEAD_BEEF);
      check_eq("miss_idx_stb", reg_wr_stb, 12'h000);
      check_eq("miss_slot2_kept", regs_out[2*32 +: 32], d2);
      tick(1'b0, 1'b1, 32'hF200_0010, 32'h0);
      check_eq("miss_off_rd", bridge_rd_data, 32'h8);
      tick(1'b0, 1'b1, 32'hFC00_0000, 32'h0);
      check_eq("miss_idx_rd", bridge_rd_data, 32'h8);

      // Bridge reset in the middle of a hold
      tick(1'b1, 1'b0, 32'hF000_0000, 32'h1);
      check_eq("ctrl_trigger", reset_sw, 1'b1);
      repeat (2999) tick_idle();
      do_reset();
      check_eq("rst_regs", regs_out, '0);
      check_eq("rst_rd", bridge_rd_data, 32'h0);
      check_eq("rst_boot", boot_done, 1'b0);
      check_eq("rst_hold", reset_sw, 1'b1);
      count_hold(n);
      check_eq("rst_hold_len", n, RC);
      check_eq("rst_boot_after", boot_done, 1'b1);

      // Randomized traffic against the model
      for (int i = 0; i < 20000; i++) begin
         int r, k;
         wr = ($urandom_range(0, 2) == 0);
         rd = ($urandom_range(0, 2) == 0);
         d  = $urandom;
         r  = $urandom_range(0, 99);
         if ($urandom_range(0, 1499) == 0) begin
            k = ($urandom_range(0, 2) == 0) ? 0 : (($urandom_range(0, 1) == 0) ? 1 : 4);
            addr = 32'hF000_0000 | (32'(k) << 24);
            d[0] = 1'b1;
            wr   = 1'b1;
         end else if (r < 60) begin
            k = safe_slots[$urandom_range(0, 9)];
            addr = 32'hF000_0000 | (32'(k) << 24);
            if (k == 0) d[0] = 1'b0;
         end else if (r < 72) begin
            addr = 32'hF000_0004;
         end else if (r < 82) begin
            addr = 32'hF000_0000 | (32'($urandom_range(12, 15)) << 24);
         end else if (r < 92) begin
            k = safe_slots[$urandom_range(0, 9)];
            addr = 32'hF000_0000 | (32'(k) << 24) | 32'($urandom_range(8, 24'hFF_FFFF));
         end else begin
            addr = 32'hE000_0000 | (32'($urandom_range(0, 11)) << 24);
         end
         tick(wr, rd, addr, d);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/interact_regbank.md
Name: interact_regbank

Overview:
Parametrised APF bridge register bank for Pocket cores, generalising the fixed interact decoder. It provides NUM_REGS-1 generic 32-bit configuration slots, a control/status slot, per-slot write strobes, clear-on-read dirty flags and a retriggerable core-reset sequencer. It sits on clk_74a between the APF bridge and per-core CDC synchronisers; all outputs are in the clk_74a domain.

Parameters:
NUM_REGS, 12, total slots including control slot 0; range 2..32
BASE_ADDR, 32'hF0000000, bridge address of slot 0
SLOT_SHIFT, 24, log2 of address stride between slots
RESET_MASK, 32'h0000_0012, bit k=1: a write to slot k retriggers core reset (bit 0 ignored)
RESET_CYCLES, 8000, clk_74a cycles core reset is held per trigger; must be >=1
INIT_VALUES, all zero, NUM_REGS*32-bit flattened reset values of slots (slot 0 field ignored)

Ports:
clk_74a  in  1  bridge clock
reset  in  1  asynchronous, active-high reset
bridge_addr  in  32  bridge address
bridge_wr  in  1  write strobe, single cycle
bridge_wr_data  in  32  write data
bridge_rd  in  1  read strobe, single cycle
bridge_rd_data  out  32  registered read data
regs_out  out  NUM_REGS*32  slot k at [k*32+:32]; slot 0 field is constant 0
reg_wr_stb  out  NUM_REGS  one-cycle pulse, cycle after an accepted write to slot k
reset_sw  out  1  1 = core held in reset
boot_done  out  1  sticky; set at end of the first hold after reset

Behaviour:
- Reset is asynchronous and active-high on clk_74a only; no other clock or reset.
- Decode: IDX_W = $clog2(NUM_REGS). Hit when bridge_addr[31:SLOT_SHIFT+IDX_W] equals the same bits of BASE_ADDR and slot index k = bridge_addr[SLOT_SHIFT+IDX_W-1:SLOT_SHIFT] < NUM_REGS.
- Offset bits [SLOT_SHIFT-1:0] must be 0, except slot 0 also decodes offset 0x4 (DIRTY).
- Misses are ignored on write and leave bridge_rd_data unchanged on read.
- Slot k≥1 write: register takes bridge_wr_data next edge; reg_wr_stb[k] pulses that same edge; dirty[k] is set.
- Slot 0 offset 0 write: bit0=1 triggers reset, other bits ignored. DIRTY writes are ignored.
- Reads: 1-cycle latency.
  - Slot k≥1 returns its register.
  - Slot 0 offset 0 returns {30'b0, reset_sw, boot_done}.
  - DIRTY returns {dirty flags, bit 0 = 0} and clears exactly the flags returned. A flag set in that same cycle stays set: set wins.
- Same-cycle bridge_rd and bridge_wr: both serviced. A read of the slot being written returns the old value.
- Reset sequencer FSM, states HOLD and RUN:
  - Trigger = accepted write to a slot with RESET_MASK bit set, or slot 0 bit0=1.
  - HOLD: reset_sw=1. Counter decrements each cycle. At 0 → RUN; boot_done <= 1.
  - RUN: reset_sw=0. Trigger → HOLD with counter=RESET_CYCLES-1.
  - A trigger in HOLD reloads the counter, so the hold restarts. A trigger on the expiry cycle wins: stay in HOLD, reload.
  - Hold length is exactly RESET_CYCLES cycles after the last trigger.
- Reset values:
  - Slots = INIT_VALUES; dirty = 0; reg_wr_stb = 0; bridge_rd_data = 0; boot_done = 0.
  - State = HOLD with counter = RESET_CYCLES-1, so reset_sw = 1 from reset assertion (power-on hold).
- Mid-hold bridge reset: returns to the reset values above and restarts the power-on hold.

Decomposition:
- Package interact_pkg:
  - state enum {ST_HOLD, ST_RUN}
  - localparams OFF_CTRL=0, OFF_DIRTY=4
  - CTRL bit positions: reset trigger = bit0; status bit0 = boot_done, bit1 = reset_sw.
- Sub-module interact_reset_seq (parameter RESET_CYCLES; ports clk_74a, reset, trigger, reset_sw, boot_done) contains the FSM and counter.

Test Plan:
- Release reset, no traffic → reset_sw=1 for exactly 8000 cycles, then 0 and boot_done=1; read 0xF0000000 returns 32'h1.
- Write 0xF2000000=32'hA5A5_0001 → regs_out[2*32+:32]=32'hA5A50001 next edge, reg_wr_stb=12'h004 for one cycle, reset_sw stays 0.
- Write slot 4 at cycle 0, again at cycle 5000 → reset_sw high until cycle 13000 exactly; slot-0 read mid-hold returns 32'h3.
- Write slots 2 and 7, read 0xF0000004 → 32'h84; second read → 32'h0. A write to slot 3 in the same cycle as the read → next read 32'h8.
- Write 0xF2000010 (nonzero offset) and 0xFC000000 (slot 12 ≥ NUM_REGS) → no register change, no strobe; a read of either leaves bridge_rd_data unchanged.
- Assert reset at cycle 3000 of a hold → outputs return to reset values and the hold restarts from 8000 cycles.
